mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU and loader/debug) in front of a single synchronous-read memory.
// Debug wins by default; a saturating burst counter bounds how long a waiting CPU is starved.
module mem_arbiter #(
   parameter int unsigned word_size = 8,
   parameter int unsigned addr_size = 8,
   parameter int unsigned max_burst = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [addr_size-1:0] cpu_addr,
   input  logic [word_size-1:0] cpu_wdata,
   output logic                 cpu_gnt,
   output logic                 cpu_rvalid,
   output logic [word_size-1:0] cpu_rdata,
   input  logic                 dbg_req,
   input  logic                 dbg_we,
   input  logic [addr_size-1:0] dbg_addr,
   input  logic [word_size-1:0] dbg_wdata,
   output logic                 dbg_gnt,
   output logic                 dbg_rvalid,
   output logic [word_size-1:0] dbg_rdata,
   input  logic                 dbg_lock,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [addr_size-1:0] mem_addr,
   output logic [word_size-1:0] mem_wdata,
   input  logic [word_size-1:0] mem_rdata
);

   localparam int unsigned cnt_w = $clog2(max_burst + 1);
   localparam logic [cnt_w-1:0] burst_top = cnt_w'(max_burst);

   logic [cnt_w-1:0]     burst_q, burst_d;
   logic                 rd_pending_q, rd_owner_q;
   logic [word_size-1:0] cpu_rdata_q, dbg_rdata_q;
   logic                 cpu_force;

   always_comb begin
      cpu_force = !dbg_lock && cpu_req && (burst_q == burst_top);
      dbg_gnt   = !rst && dbg_req && !cpu_force;
      cpu_gnt   = !rst && cpu_req && !dbg_lock && !dbg_gnt;

      mem_en    = cpu_gnt || dbg_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end

      burst_d = burst_q;
      if (cpu_gnt || !cpu_req) begin
         burst_d = '0;
      end else if (dbg_gnt && (burst_q != burst_top)) begin
         burst_d = burst_q + cnt_w'(1);
      end

      // rvalid is gated by rst so a read granted just before reset never returns.
      cpu_rvalid = !rst && rd_pending_q && !rd_owner_q;
      dbg_rvalid = !rst && rd_pending_q && rd_owner_q;
      cpu_rdata  = rst ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
      dbg_rdata  = rst ? '0 : (dbg_rvalid ? mem_rdata : dbg_rdata_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         burst_q      <= '0;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         burst_q      <= burst_d;
         rd_pending_q <= mem_en && !mem_we;
         rd_owner_q   <= dbg_gnt;
         cpu_rdata_q  <= cpu_rdata;
         dbg_rdata_q  <= dbg_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst, dbg_lock;
   logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] mem [256];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_gnt   (dbg_gnt),
      .dbg_rvalid(dbg_rvalid),
      .dbg_rdata (dbg_rdata),
      .dbg_lock  (dbg_lock),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   typedef struct {
      logic       rst, lock, creq, cwe;
      logic [7:0] caddr, cwd;
      logic       dreq, dwe;
      logic [7:0] daddr, dwd;
      logic [37:0] exp;
   } vec_t;

   vec_t vecs[$];

   // exp = {cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
   //        cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata}
   task automatic add(input logic r, input logic lk,
                      input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                      input logic cg, input logic dg, input logic me, input logic mw,
                      input logic [7:0] ma, input logic [7:0] md,
                      input logic crv, input logic [7:0] crd,
                      input logic drv, input logic [7:0] drd);
      vec_t v;
      v.rst = r; v.lock = lk; v.creq = cr; v.cwe = cw; v.caddr = ca; v.cwd = cd;
      v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwd = dd;
      v.exp = {cg, dg, me, mw, ma, md, crv, crd, drv, drd};
      vecs.push_back(v);
   endtask

   function automatic logic [37:0] actual();
      return {cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
              cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
   endfunction

   task automatic chk(input string name, input logic [37:0] got, input logic [37:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; dbg_lock = v.lock;
      cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
      dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
   endtask

   initial begin
      int waits;
      vec_t v;
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      mem[8'h80] = 8'h06;
      mem[8'h81] = 8'h01;
      rst = 1'b1; dbg_lock = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // reset with both requesting: nothing granted
      add(1,0, 1,0,8'h10,8'h00, 1,0,8'h11,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00);
      add(1,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00);
      // locked dbg write 0x55 -> 0x82 while cpu waits
      add(0,1, 1,0,8'h82,8'h00, 1,1,8'h82,8'h55, 0,1,1,1,8'h82,8'h55, 0,8'h00, 0,8'h00);
      add(0,1, 1,0,8'h82,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00);
      // cpu read 0x82 alone
      add(0,0, 1,0,8'h82,8'h00, 0,0,8'h00,8'h00, 1,0,1,0,8'h82,8'h00, 0,8'h00, 0,8'h00);
      add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 1,8'h55, 0,8'h00);
      add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h55, 0,8'h00);
      // alternating reads dbg@0x80, cpu@0x81
      add(0,0, 0,0,8'h00,8'h00, 1,0,8'h80,8'h00, 0,1,1,0,8'h80,8'h00, 0,8'h55, 0,8'h00);
      add(0,0, 1,0,8'h81,8'h00, 0,0,8'h00,8'h00, 1,0,1,0,8'h81,8'h00, 0,8'h55, 1,8'h06);
      add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 1,8'h01, 0,8'h06);
      // cpu write 0x09 -> 0x8C
      add(0,0, 1,1,8'h8C,8'h09, 0,0,8'h00,8'h00, 1,0,1,1,8'h8C,8'h09, 0,8'h01, 0,8'h06);
      add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h01, 0,8'h06);
      // both held: dbg x4, cpu, repeating
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            add(0,0, 1,1,8'h90,8'hA1, 1,1,8'h91,8'hB2, 0,1,1,1,8'h91,8'hB2, 0,8'h01, 0,8'h06);
         add(0,0, 1,1,8'h90,8'hA1, 1,1,8'h91,8'hB2, 1,0,1,1,8'h90,8'hA1, 0,8'h01, 0,8'h06);
      end
      // read granted, then reset: no rvalid, everything cleared
      add(0,0, 1,0,8'h80,8'h00, 0,0,8'h00,8'h00, 1,0,1,0,8'h80,8'h00, 0,8'h01, 0,8'h06);
      add(1,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00);
      add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00);
      // grant available right after reset
      add(0,0, 0,0,8'h00,8'h00, 1,0,8'h81,8'h00, 0,1,1,0,8'h81,8'h00, 0,8'h00, 0,8'h00);
      add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00, 0,8'h00, 1,8'h01);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("vec%0d", i), actual(), vecs[i].exp);
      end

      // locked for 6 cycles with cpu waiting: burst saturates, cpu wins on unlock
      v = vecs[0];
      v.rst = 0; v.lock = 1;
      v.creq = 1; v.cwe = 1; v.caddr = 8'hA0; v.cwd = 8'h11;
      v.dreq = 1; v.dwe = 1; v.daddr = 8'hA1; v.dwd = 8'h22;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(v);
         #1;
         chk($sformatf("lock_gnt%0d", k), 38'(actual() >> 36), 38'(2'b01));
      end
      @(negedge clk);
      v.lock = 0;
      drive(v);
      #1;
      chk("unlock_cpu_first", 38'(actual() >> 36), 38'(2'b10));

      // bounded wait: cpu must be regranted after exactly max_burst dbg grants
      waits = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         if (cpu_gnt) break;
         if (dbg_gnt) waits++;
      end
      chk("cpu_wait_bound", 38'(waits), 38'(4));
      chk("cpu_regranted", 38'(cpu_gnt), 38'(1));

      @(negedge clk);
      cpu_req = 0; dbg_req = 0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
